codec_reg_scheduler: RTL and testbench

Shares the audio codec's write-only SPI control port between two register-write requesters: the boot configurator (port A) and runtime controls such as volume and mute (port B). It arbitrates the requests and drives the existing SPI master through its DATA/TRG/RDY handshake. After each transfer it generates the chip-select latch pulse the codec needs. It also keeps a shadow copy of codec registers 0x00–0x0F, so it can suppress redundant writes and give software readback.

---
 rtl/codec_reg_scheduler.sv | 158 +++++++++++++++
 tb/tb_codec_reg_scheduler.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/codec_reg_scheduler.sv
// codec_reg_scheduler
// Shares the codec's write-only SPI control port between two register-write
// requesters. Port A (boot configurator) has fixed priority over port B
// (runtime controls). A granted write is handed to the SPI master through its
// DATA/TRG/RDY handshake, then cs is pulsed low for CS_PULSE cycles so the
// codec latches the word. A shadow of codec registers 0x00-0x0F suppresses
// redundant writes and provides readback.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   a_req/a_addr/a_data   requester A write request (high priority)
//   a_ack                 one-cycle accept pulse for A
//   b_req/b_addr/b_data   requester B write request (low priority)
//   b_ack                 one-cycle accept pulse for B
//   spi_data              {addr[6:0], data[8:0]} word to the SPI master
//   spi_trg               one-cycle start pulse to the SPI master
//   spi_rdy               SPI master idle flag
//   cs                    codec chip select, idles high
//   busy                  high whenever the FSM is not idle
//   rd_addr               shadow readback address
//   rd_data/rd_valid      registered shadow data and valid bit at rd_addr
//   skip_count            number of suppressed writes, wraps at 255
module codec_reg_scheduler #(
  parameter int CS_PULSE       = 2,
  parameter bit SKIP_REDUNDANT = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic [6:0]  a_addr,
  input  logic [8:0]  a_data,
  output logic        a_ack,
  input  logic        b_req,
  input  logic [6:0]  b_addr,
  input  logic [8:0]  b_data,
  output logic        b_ack,
  output logic [15:0] spi_data,
  output logic        spi_trg,
  input  logic        spi_rdy,
  output logic        cs,
  output logic        busy,
  input  logic [3:0]  rd_addr,
  output logic [8:0]  rd_data,
  output logic        rd_valid,
  output logic [7:0]  skip_count
);

  typedef enum logic [1:0] {IDLE, LOAD, XFER, LATCH} state_t;

  localparam logic [3:0] LAST_LATCH = 4'(CS_PULSE - 1);

  state_t      state;
  logic [3:0]  latch_cnt;
  logic [8:0]  shadow_data [16];
  logic [15:0] shadow_valid;

  logic        grant_ok;
  logic [6:0]  req_addr;
  logic [8:0]  req_data;
  logic        skip;
  logic [6:0]  lat_addr;
  logic [8:0]  lat_data;

  // Acks are decoded combinationally in the cycle the FSM accepts, so a
  // requester can drop req on the following cycle and back-to-back skipped
  // writes can be accepted one per cycle. Gated by reset so a request held
  // through reset is only accepted once reset has been released.
  assign grant_ok = !reset && (state == IDLE) && spi_rdy;
  assign a_ack    = grant_ok && a_req;
  assign b_ack    = grant_ok && !a_req && b_req;

  assign req_addr = a_req ? a_addr : b_addr;
  assign req_data = a_req ? a_data : b_data;

  // Address 0x0F is the codec reset and addresses above it are not shadowed,
  // so only 0x00-0x0E can ever be suppressed.
  assign skip = SKIP_REDUNDANT && (req_addr < 7'h0F) &&
                shadow_valid[req_addr[3:0]] &&
                (shadow_data[req_addr[3:0]] == req_data);

  // The word held in spi_data is the one that was sent, so the shadow is
  // updated from it at the end of the latch pulse.
  assign lat_addr = spi_data[15:9];
  assign lat_data = spi_data[8:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      spi_trg      <= 1'b0;
      cs           <= 1'b1;
      busy         <= 1'b0;
      spi_data     <= 16'h0000;
      skip_count   <= 8'h00;
      latch_cnt    <= 4'h0;
      shadow_valid <= 16'h0000;
      for (int i = 0; i < 16; i++) begin
        shadow_data[i] <= 9'h000;
      end
    end else begin
      case (state)
        IDLE: begin
          if (a_ack || b_ack) begin
            spi_data <= {req_addr, req_data};
            if (skip) begin
              skip_count <= skip_count + 8'd1;
            end else begin
              state   <= LOAD;
              spi_trg <= 1'b1;
              busy    <= 1'b1;
            end
          end
        end
        LOAD: begin
          spi_trg <= 1'b0;
          state   <= XFER;
        end
        XFER: begin
          // The master drops RDY when it samples TRG, so RDY high here
          // means the shift has finished.
          if (spi_rdy) begin
            state     <= LATCH;
            cs        <= 1'b0;
            latch_cnt <= LAST_LATCH;
          end
        end
        LATCH: begin
          if (latch_cnt == 4'h0) begin
            state <= IDLE;
            cs    <= 1'b1;
            busy  <= 1'b0;
            if (lat_addr < 7'h0F) begin
              shadow_data[lat_addr[3:0]]  <= lat_data;
              shadow_valid[lat_addr[3:0]] <= 1'b1;
            end else if (lat_addr == 7'h0F) begin
              shadow_valid <= 16'h0000;
            end
          end else begin
            latch_cnt <= latch_cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Readback sees the shadow as of the previous cycle; an update landing in
  // the same cycle as the read returns the old contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data  <= 9'h000;
      rd_valid <= 1'b0;
    end else begin
      rd_data  <= shadow_data[rd_addr];
      rd_valid <= shadow_valid[rd_addr];
    end
  end

endmodule

// File: tb/tb_codec_reg_scheduler.sv
// tb_codec_reg_scheduler
// Bench for codec_reg_scheduler. Two instances are built: index 0 with
// CS_PULSE=2 and index 1 with CS_PULSE=5, each driven by its own SPI master
// model whose RDY low time is programmable. A register-map model of the codec
// shadow predicts skips, skip_count and readback.
module tb_codec_reg_scheduler;

  logic clk = 1'b0;
  logic reset;

  logic [1:0]       a_req, b_req;
  logic [1:0][6:0]  a_addr, b_addr;
  logic [1:0][8:0]  a_data, b_data;
  logic [1:0]       a_ack, b_ack;
  logic [1:0][15:0] spi_data;
  logic [1:0]       spi_trg;
  logic [1:0]       spi_rdy = 2'b11;
  logic [1:0]       cs, busy;
  logic [1:0][3:0]  rd_addr;
  logic [1:0][8:0]  rd_data;
  logic [1:0]       rd_valid;
  logic [1:0][7:0]  skip_count;

  int dly[2]     = '{2, 2};
  int rdy_cnt[2] = '{0, 0};
  int trg_cnt[2] = '{0, 0};

  bit         m_valid [2][16];
  logic [8:0] m_data  [2][16];
  int         m_skips [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    codec_reg_scheduler #(
      .CS_PULSE       (g == 0 ? 2 : 5),
      .SKIP_REDUNDANT (1'b1)
    ) dut (
      .clk        (clk),
      .reset      (reset),
      .a_req      (a_req[g]),
      .a_addr     (a_addr[g]),
      .a_data     (a_data[g]),
      .a_ack      (a_ack[g]),
      .b_req      (b_req[g]),
      .b_addr     (b_addr[g]),
      .b_data     (b_data[g]),
      .b_ack      (b_ack[g]),
      .spi_data   (spi_data[g]),
      .spi_trg    (spi_trg[g]),
      .spi_rdy    (spi_rdy[g]),
      .cs         (cs[g]),
      .busy       (busy[g]),
      .rd_addr    (rd_addr[g]),
      .rd_data    (rd_data[g]),
      .rd_valid   (rd_valid[g]),
      .skip_count (skip_count[g])
    );
  end

  // SPI master model: drops RDY on the edge that samples TRG and holds it
  // low for dly[] cycles.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (reset) begin
        spi_rdy[g] <= 1'b1;
        rdy_cnt[g] <= 0;
      end else if (spi_trg[g]) begin
        spi_rdy[g] <= 1'b0;
        rdy_cnt[g] <= dly[g];
        trg_cnt[g] <= trg_cnt[g] + 1;
      end else if (!spi_rdy[g]) begin
        if (rdy_cnt[g] <= 1) spi_rdy[g] <= 1'b1;
        else rdy_cnt[g] <= rdy_cnt[g] - 1;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pulse_of(input int u);
    return (u == 0) ? 2 : 5;
  endfunction

  function automatic bit model_skip(input int u, input logic [6:0] addr, input logic [8:0] data);
    if (addr >= 7'h0F) return 1'b0;
    return m_valid[u][addr[3:0]] && (m_data[u][addr[3:0]] == data);
  endfunction

  task automatic model_update(input int u, input logic [6:0] addr, input logic [8:0] data);
    if (addr < 7'h0F) begin
      m_valid[u][addr[3:0]] = 1'b1;
      m_data[u][addr[3:0]]  = data;
    end else if (addr == 7'h0F) begin
      for (int i = 0; i < 16; i++) m_valid[u][i] = 1'b0;
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_skips[u] = 0;
      for (int i = 0; i < 16; i++) begin
        m_valid[u][i] = 1'b0;
        m_data[u][i]  = 9'h000;
      end
    end
  endtask

  task automatic apply_stimulus(input int u, input bit use_b, input logic [6:0] addr, input logic [8:0] data);
    if (use_b) begin
      b_req[u]  = 1'b1;
      b_addr[u] = addr;
      b_data[u] = data;
    end else begin
      a_req[u]  = 1'b1;
      a_addr[u] = addr;
      a_data[u] = data;
    end
  endtask

  task automatic release_req(input int u, input bit use_b);
    if (use_b) b_req[u] = 1'b0;
    else a_req[u] = 1'b0;
  endtask

  task automatic wait_ack(input int u, input bit use_b, output int waited);
    waited = 0;
    #1;
    while (((use_b ? b_ack[u] : a_ack[u]) !== 1'b1) && waited < 300) begin
      tick();
      #1;
      waited++;
    end
    check_output("ack_arrives", 32'(use_b ? b_ack[u] : a_ack[u]), 1);
    check_output("other_ack_quiet", 32'(use_b ? a_ack[u] : b_ack[u]), 0);
    check_output("ack_only_when_rdy", 32'(spi_rdy[u]), 1);
  endtask

  // Called in the ack cycle; follows the write to its end and checks it.
  task automatic finish_write(input int u, input bit use_b, input logic [6:0] addr, input logic [8:0] data);
    bit          skip;
    bit          ok;
    int          trg0;
    int          low;
    logic [15:0] word;
    word = {addr, data};
    skip = model_skip(u, addr, data);
    trg0 = trg_cnt[u];
    tick();
    release_req(u, use_b);
    check_output("rd_valid_t1", 32'(rd_valid[u]), 32'(m_valid[u][rd_addr[u]]));
    if (m_valid[u][rd_addr[u]])
      check_output("rd_data_t1", 32'(rd_data[u]), 32'(m_data[u][rd_addr[u]]));
    if (skip) begin
      m_skips[u]++;
      check_output("skip_no_trg", 32'(spi_trg[u]), 0);
      check_output("skip_not_busy", 32'(busy[u]), 0);
      check_output("skip_count", 32'(skip_count[u]), 32'(m_skips[u] % 256));
    end else begin
      check_output("trg_pulse", 32'(spi_trg[u]), 1);
      check_output("spi_word", 32'(spi_data[u]), 32'(word));
      check_output("busy_after_grant", 32'(busy[u]), 1);
      tick();
      check_output("trg_single", 32'(spi_trg[u]), 0);
      ok  = 1'b1;
      low = 0;
      while (spi_rdy[u] !== 1'b1 && low < 500) begin
        if (cs[u] !== 1'b1 || spi_data[u] !== word || busy[u] !== 1'b1 ||
            a_ack[u] !== 1'b0 || b_ack[u] !== 1'b0) ok = 1'b0;
        low++;
        tick();
      end
      check_output("rdy_low_cycles", 32'(low), 32'(dly[u]));
      check_output("hold_during_xfer", 32'(ok), 1);
      check_output("cs_high_at_rdy", 32'(cs[u]), 1);
      ok = 1'b1;
      for (int k = 0; k < pulse_of(u); k++) begin
        tick();
        if (cs[u] !== 1'b0 || busy[u] !== 1'b1 || spi_data[u] !== word ||
            a_ack[u] !== 1'b0 || b_ack[u] !== 1'b0) ok = 1'b0;
      end
      check_output("cs_pulse", 32'(ok), 1);
      tick();
      check_output("cs_release", 32'(cs[u]), 1);
      check_output("busy_release", 32'(busy[u]), 0);
      check_output("trg_count", 32'(trg_cnt[u]), 32'(trg0 + 1));
      model_update(u, addr, data);
    end
  endtask

  task automatic do_write(input int u, input bit use_b, input logic [6:0] addr, input logic [8:0] data, input int delay);
    int w;
    dly[u] = delay;
    apply_stimulus(u, use_b, addr, data);
    wait_ack(u, use_b, w);
    finish_write(u, use_b, addr, data);
  endtask

  task automatic check_rd(input int u, input logic [3:0] a);
    rd_addr[u] = a;
    tick();
    check_output("rd_valid", 32'(rd_valid[u]), 32'(m_valid[u][a]));
    if (m_valid[u][a]) check_output("rd_data", 32'(rd_data[u]), 32'(m_data[u][a]));
  endtask

  initial begin
    int         w;
    int         s0;
    int         u;
    int         guard;
    int         r;
    logic [6:0] ra;
    logic [8:0] rdat;

    reset   = 1'b1;
    a_req   = '0;
    b_req   = '0;
    a_addr  = '0;
    b_addr  = '0;
    a_data  = '0;
    b_data  = '0;
    rd_addr = '0;
    model_reset();
    repeat (3) tick();

    // Reset values on both instances.
    for (int i = 0; i < 2; i++) begin
      check_output("rst_trg", 32'(spi_trg[i]), 0);
      check_output("rst_cs", 32'(cs[i]), 1);
      check_output("rst_busy", 32'(busy[i]), 0);
      check_output("rst_spi_data", 32'(spi_data[i]), 0);
      check_output("rst_skip_count", 32'(skip_count[i]), 0);
      check_output("rst_rd_data", 32'(rd_data[i]), 0);
      check_output("rst_rd_valid", 32'(rd_valid[i]), 0);
    end
    reset = 1'b0;
    tick();

    // Priority tie: A served first, B granted on the first idle cycle.
    $display("[TB] priority tie");
    dly[0] = 3;
    apply_stimulus(0, 1'b0, 7'h04, 9'h011);
    apply_stimulus(0, 1'b1, 7'h02, 9'h17C);
    wait_ack(0, 1'b0, w);
    finish_write(0, 1'b0, 7'h04, 9'h011);
    wait_ack(0, 1'b1, w);
    check_output("b_ack_first_idle_cycle", 32'(w), 0);
    finish_write(0, 1'b1, 7'h02, 9'h17C);

    // Redundant write suppression.
    $display("[TB] redundant skip");
    do_write(0, 1'b0, 7'h00, 9'h09F, 2);
    do_write(0, 1'b0, 7'h00, 9'h09F, 2);
    check_output("skip_count_one", 32'(skip_count[0]), 1);
    check_rd(0, 4'h0);

    // Held request on a valid shadow entry: one ack per cycle.
    apply_stimulus(0, 1'b0, 7'h00, 9'h09F);
    #1;
    for (int i = 0; i < 3; i++) begin
      check_output("b2b_ack", 32'(a_ack[0]), 1);
      check_output("b2b_no_trg", 32'(spi_trg[0]), 0);
      tick();
      #1;
    end
    release_req(0, 1'b0);
    m_skips[0] += 3;
    check_output("b2b_skip_count", 32'(skip_count[0]), 32'(m_skips[0]));

    // Codec reset clears the shadow.
    $display("[TB] codec reset");
    do_write(0, 1'b0, 7'h09, 9'h001, 2);
    do_write(0, 1'b0, 7'h0F, 9'h000, 2);
    check_rd(0, 4'h9);
    check_output("rd_valid_9_cleared", 32'(rd_valid[0]), 0);
    do_write(0, 1'b0, 7'h09, 9'h001, 2);

    // Out-of-range address is never skipped.
    $display("[TB] out of range");
    s0 = m_skips[0];
    do_write(0, 1'b0, 7'h12, 9'h0AA, 2);
    do_write(0, 1'b0, 7'h12, 9'h0AA, 2);
    check_output("oor_no_skip", 32'(skip_count[0]), 32'(s0));

    // Slow SPI master on both CS_PULSE settings.
    $display("[TB] slow spi");
    do_write(0, 1'b0, 7'h03, 9'h1AA, 40);
    do_write(1, 1'b1, 7'h06, 9'h055, 40);

    // Randomized writes against the register-map model.
    $display("[TB] random writes");
    for (int i = 0; i < 40; i++) begin
      u = i % 2;
      r = $urandom_range(0, 9);
      if (r < 7) ra = 7'($urandom_range(0, 4));
      else if (r == 7) ra = 7'h0F;
      else ra = 7'($urandom_range(16, 127));
      rdat = 9'($urandom_range(0, 3));
      rd_addr[u] = 4'($urandom_range(0, 15));
      do_write(u, 1'($urandom_range(0, 1)), ra, rdat, $urandom_range(1, 4));
    end
    for (int i = 0; i < 2; i++) begin
      check_output("rand_skip_count", 32'(skip_count[i]), 32'(m_skips[i] % 256));
      for (int a = 0; a < 16; a++) check_rd(i, 4'(a));
    end

    // Reset on the first cs-low cycle, with the request held through reset.
    $display("[TB] reset during latch");
    dly[0] = 3;
    apply_stimulus(0, 1'b0, 7'h05, 9'h123);
    wait_ack(0, 1'b0, w);
    tick();
    release_req(0, 1'b0);
    guard = 0;
    tick();
    while (spi_rdy[0] !== 1'b1 && guard < 100) begin
      tick();
      guard++;
    end
    tick();
    check_output("latch_first_cs_low", 32'(cs[0]), 0);
    reset = 1'b1;
    apply_stimulus(0, 1'b0, 7'h05, 9'h123);
    rd_addr[0] = 4'h5;
    tick();
    #1;
    check_output("reset_cs_high", 32'(cs[0]), 1);
    check_output("reset_busy_low", 32'(busy[0]), 0);
    check_output("reset_trg_low", 32'(spi_trg[0]), 0);
    check_output("reset_no_ack", 32'(a_ack[0]), 0);
    check_output("reset_skip_count", 32'(skip_count[0]), 0);
    model_reset();
    reset = 1'b0;
    wait_ack(0, 1'b0, w);
    check_output("reack_immediate", 32'(w), 0);
    finish_write(0, 1'b0, 7'h05, 9'h123);
    check_rd(0, 4'h5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
